// File: rtl/ibex_shadow_stack_ctrl_pkg.sv
// Shared types and helpers for the shadow-stack controller slice.
// Decodes link registers and defines queue entries, FSM states and fault causes.
package ibex_shadow_stack_ctrl_pkg;

    typedef enum logic {
        SS_PUSH = 1'b0,
        SS_POP  = 1'b1
    } ss_op_e;

    typedef enum logic [1:0] {
        SS_OFF   = 2'd0,
        SS_RUN   = 2'd1,
        SS_DRAIN = 2'd2,
        SS_FAULT = 2'd3
    } ss_state_e;

    typedef enum logic [1:0] {
        SS_CAUSE_NONE = 2'b00,
        SS_CAUSE_PUSH = 2'b01,
        SS_CAUSE_POP  = 2'b10
    } ss_cause_e;

    typedef struct packed {
        ss_op_e      op;
        logic [31:0] addr;
    } ss_entry_t;

    localparam logic [6:0] OPCODE_JAL  = 7'h6f;
    localparam logic [6:0] OPCODE_JALR = 7'h67;

    // x1 (ra) and x5 (t0) are the link registers named by the RISC-V hint rules.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ibex_shadow_stack_fifo.sv
// Operation queue: up to two writes and one read per cycle, with a synchronous flush.
// Writes that do not fit are dropped; slot 0 always lands before slot 1.
module ibex_shadow_stack_fifo
    import ibex_shadow_stack_ctrl_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [1:0]      wr_en_i,
    input  ss_entry_t       wr_data0_i,
    input  ss_entry_t       wr_data1_i,
    input  logic            rd_en_i,
    output ss_entry_t       rd_data_o,
    output logic [PtrW:0]   count_o
);

    ss_entry_t       mem [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   count_q;
    logic [PtrW:0]   space;
    logic            rd, acc0, acc1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd    = rd_en_i && (count_q != '0);
        space = (PtrW+1)'(Depth) - count_q + (PtrW+1)'(rd);
        acc0  = wr_en_i[0] && (space != '0);
        acc1  = wr_en_i[1] && (acc0 ? (space > (PtrW+1)'(1)) : (space != '0));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_q + PtrW'(rd);
            wptr_q  <= wptr_q + PtrW'(acc0) + PtrW'(acc1);
            count_q <= count_q + (PtrW+1)'(acc0) + (PtrW+1)'(acc1) - (PtrW+1)'(rd);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (acc0) mem[wptr_q] <= wr_data0_i;
            if (acc1) mem[wptr_q + PtrW'(acc0)] <= wr_data1_i;
        end
    end

    assign rd_data_o = mem[rptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/ibex_shadow_stack_ctrl.sv
// Shadow-stack sequencer: classifies retiring jumps into push/pop ops, queues them
// and issues one per cycle, converting stack errors into a sticky fault and an alert.
module ibex_shadow_stack_ctrl
    import ibex_shadow_stack_ctrl_pkg::*;
#(
    parameter int unsigned FifoDepth = 4,
    parameter bit          RV32E     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clear_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic        instr_is_compressed_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] jump_target_i,
    input  logic        stack_err_i,
    output logic        push_o,
    output logic [31:0] push_addr_o,
    output logic        pop_o,
    output logic [31:0] pop_addr_o,
    output logic        stall_o,
    output logic        alert_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);

    ss_state_e     state_q;
    ss_cause_e     cause_q;
    logic          alert_q, fault_q;

    logic [6:0]    opcode;
    logic [4:0]    rd, rs1;
    logic          rd_link, rs1_link, classify;
    logic [31:0]   link_addr;
    logic [1:0]    enq_en;
    ss_entry_t     enq0, enq1, head;
    logic [PtrW:0] count;
    logic          fifo_empty, issue, err_issue;
    logic          unused_instr;

    assign opcode    = instr_i[6:0];
    assign rd        = instr_i[11:7];
    assign rs1       = instr_i[19:15];
    // x1/x5 are below x16, so the RV32E restriction never changes the result.
    assign rd_link   = is_link_reg(rd)  && !(RV32E && rd[4]);
    assign rs1_link  = is_link_reg(rs1) && !(RV32E && rs1[4]);
    assign link_addr = pc_i + (instr_is_compressed_i ? 32'd2 : 32'd4);
    assign classify  = en_i && instr_valid_i && (state_q == SS_RUN);
    assign unused_instr = ^{instr_i[31:20], instr_i[14:12]};

    always_comb begin
        enq_en = 2'b00;
        enq0   = '{op: SS_PUSH, addr: link_addr};
        enq1   = '{op: SS_PUSH, addr: link_addr};
        if (classify) begin
            if (opcode == OPCODE_JAL) begin
                if (rd_link) enq_en = 2'b01;
            end else if (opcode == OPCODE_JALR) begin
                if (rd_link && rs1_link && (rd != rs1)) begin
                    // Coroutine swap: pop the old return address before pushing the new one.
                    enq0   = '{op: SS_POP, addr: jump_target_i};
                    enq_en = 2'b11;
                end else if (rd_link) begin
                    enq_en = 2'b01;
                end else if (rs1_link) begin
                    enq0   = '{op: SS_POP, addr: jump_target_i};
                    enq_en = 2'b01;
                end
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign issue      = ((state_q == SS_RUN) || (state_q == SS_DRAIN)) && !fifo_empty;
    assign err_issue  = issue && stack_err_i;

    ibex_shadow_stack_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (clear_i || err_issue),
        .wr_en_i    (enq_en),
        .wr_data0_i (enq0),
        .wr_data1_i (enq1),
        .rd_en_i    (issue),
        .rd_data_o  (head),
        .count_o    (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SS_OFF;
            alert_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= SS_CAUSE_NONE;
        end else begin
            alert_q <= 1'b0;
            if (clear_i) begin
                state_q <= SS_OFF;
                fault_q <= 1'b0;
                cause_q <= SS_CAUSE_NONE;
            end else if (err_issue) begin
                state_q <= SS_FAULT;
                alert_q <= 1'b1;
                fault_q <= 1'b1;
                cause_q <= (head.op == SS_PUSH) ? SS_CAUSE_PUSH : SS_CAUSE_POP;
            end else begin
                unique case (state_q)
                    SS_OFF:   if (en_i) state_q <= SS_RUN;
                    SS_RUN:   if (!en_i) state_q <= SS_DRAIN;
                    SS_DRAIN: begin
                        if (en_i)            state_q <= SS_RUN;
                        else if (fifo_empty) state_q <= SS_OFF;
                    end
                    SS_FAULT: state_q <= SS_FAULT;
                    default:  state_q <= SS_OFF;
                endcase
            end
        end
    end

    assign push_o        = issue && (head.op == SS_PUSH);
    assign pop_o         = issue && (head.op == SS_POP);
    assign push_addr_o   = push_o ? head.addr : 32'd0;
    assign pop_addr_o    = pop_o  ? head.addr : 32'd0;
    assign stall_o       = (state_q == SS_RUN) && (count > (PtrW+1)'(FifoDepth - 2));
    assign alert_o       = alert_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_ibex_shadow_stack_ctrl.sv
// Directed bench: a vector table for the per-cycle behaviour plus hand-written
// drain and async-reset sequences.
module tb_ibex_shadow_stack_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i, clear_i, instr_valid_i, instr_is_compressed_i, stack_err_i;
    logic [31:0] instr_i, pc_i, jump_target_i;
    logic        push_o, pop_o, stall_o, alert_o, fault_o;
    logic [31:0] push_addr_o, pop_addr_o;
    logic [1:0]  fault_cause_o;

    int checks = 0;
    int errors = 0;

    ibex_shadow_stack_ctrl #(
        .FifoDepth (4),
        .RV32E     (1'b0)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .en_i                  (en_i),
        .clear_i               (clear_i),
        .instr_valid_i         (instr_valid_i),
        .instr_i               (instr_i),
        .instr_is_compressed_i (instr_is_compressed_i),
        .pc_i                  (pc_i),
        .jump_target_i         (jump_target_i),
        .stack_err_i           (stack_err_i),
        .push_o                (push_o),
        .push_addr_o           (push_addr_o),
        .pop_o                 (pop_o),
        .pop_addr_o            (pop_addr_o),
        .stall_o               (stall_o),
        .alert_o               (alert_o),
        .fault_o               (fault_o),
        .fault_cause_o         (fault_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        en, clr, err, valid, comp;
        logic [31:0] instr, pc, tgt;
        logic [70:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'h0, rd, 7'h6f};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h0, rs1, 3'b000, rd, 7'h67};
    endfunction

    function automatic logic [70:0] o(input logic push, input logic [31:0] pa, input logic pop,
                                      input logic [31:0] pp, input logic stall, input logic alert,
                                      input logic fault, input logic [1:0] cause);
        return {push, pa, pop, pp, stall, alert, fault, cause};
    endfunction

    function automatic logic [70:0] pu(input logic [31:0] a);
        return o(1'b1, a, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction

    function automatic logic [70:0] po(input logic [31:0] a);
        return o(1'b0, 32'd0, 1'b1, a, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction

    function automatic vec_t mk(input string n, input logic en, input logic clr, input logic err,
                                input logic valid, input logic comp, input logic [31:0] instr,
                                input logic [31:0] pc, input logic [31:0] tgt, input logic [70:0] exp);
        vec_t v;
        v.name = n; v.en = en; v.clr = clr; v.err = err; v.valid = valid; v.comp = comp;
        v.instr = instr; v.pc = pc; v.tgt = tgt; v.exp = exp;
        return v;
    endfunction

    function automatic logic [70:0] outs();
        return {push_o, push_addr_o, pop_o, pop_addr_o, stall_o, alert_o, fault_o, fault_cause_o};
    endfunction

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic en, input logic clr, input logic err, input logic valid,
                         input logic comp, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] tgt);
        en_i = en; clear_i = clr; stack_err_i = err; instr_valid_i = valid;
        instr_is_compressed_i = comp; instr_i = instr; pc_i = pc; jump_target_i = tgt;
    endtask

    // Protocol monitor: upstream must hold while stalled, and an issue is push xor pop.
    always @(posedge clk_i) begin
        if (rst_ni && instr_valid_i && stall_o) begin
            errors++;
            $display("FAIL stall_protocol: instruction retired while stall_o=1");
        end
        if (rst_ni && push_o && pop_o) begin
            errors++;
            $display("FAIL push_pop_exclusive: push_o=1 and pop_o=1");
        end
    end

    logic [70:0] zero;
    logic [32:0] seen[$];
    logic [32:0] exp_ops[3];

    initial begin
        zero = o(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Each row: inputs applied for one cycle; outputs compared just after that edge.
        // stack_err_i in a row answers the op presented by the previous row.
        tbl.push_back(mk("enable",      1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("jal_x1",      1, 0, 0, 1, 0, jal(1),      32'h100, 32'h200, pu(32'h104)));
        tbl.push_back(mk("ret_x1",      1, 0, 0, 1, 0, jalr(0, 1),  32'h300, 32'h104, po(32'h104)));
        tbl.push_back(mk("idle0",       1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("c_jal",       1, 0, 0, 1, 1, jal(1),      32'h200, 32'h240, pu(32'h202)));
        tbl.push_back(mk("jalr_x7",     1, 0, 0, 1, 0, jalr(0, 7),  32'h210, 32'h1234, zero));
        tbl.push_back(mk("jalr_x1_x1",  1, 0, 0, 1, 0, jalr(1, 1),  32'h400, 32'h440, pu(32'h404)));
        tbl.push_back(mk("coro_pop",    1, 0, 0, 1, 0, jalr(1, 5),  32'h300, 32'h500, po(32'h500)));
        tbl.push_back(mk("coro_push",   1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, pu(32'h304)));
        tbl.push_back(mk("idle1",       1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("coro_a",      1, 0, 0, 1, 0, jalr(5, 1),  32'h600, 32'h700, po(32'h700)));
        tbl.push_back(mk("coro_b_stall",1, 0, 0, 1, 0, jalr(1, 5),  32'h800, 32'h900,
                         o(1'b1, 32'h604, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00)));
        tbl.push_back(mk("stall_hold",  1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, po(32'h900)));
        tbl.push_back(mk("drain_q1",    1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, pu(32'h804)));
        tbl.push_back(mk("idle2",       1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("bad_ret",     1, 0, 0, 1, 0, jalr(0, 1),  32'h980, 32'h999, po(32'h999)));
        tbl.push_back(mk("err_pop",     1, 0, 1, 1, 0, jal(1),      32'hA00, 32'h000,
                         o(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 2'b10)));
        tbl.push_back(mk("fault_retire",1, 0, 0, 1, 0, jal(1),      32'hB00, 32'h000,
                         o(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 2'b10)));
        tbl.push_back(mk("fault_idle",  1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000,
                         o(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 2'b10)));
        tbl.push_back(mk("clear_pop",   1, 1, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("reenable0",   1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("call_x5",     1, 0, 0, 1, 0, jal(5),      32'hC00, 32'h000, pu(32'hC04)));
        tbl.push_back(mk("err_push",    1, 0, 1, 0, 0, 32'd0,       32'h000, 32'h000,
                         o(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 2'b01)));
        tbl.push_back(mk("clear_push",  1, 1, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("reenable1",   1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));
        tbl.push_back(mk("call2",       1, 0, 0, 1, 0, jal(1),      32'hD00, 32'h000, pu(32'hD04)));
        tbl.push_back(mk("clear_vs_err",1, 1, 1, 1, 0, jal(5),      32'hE00, 32'h000, zero));
        tbl.push_back(mk("reenable2",   1, 0, 0, 0, 0, 32'd0,       32'h000, 32'h000, zero));

        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        #12;
        check("reset_outputs", outs(), zero);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].err, tbl[i].valid, tbl[i].comp,
                  tbl[i].instr, tbl[i].pc, tbl[i].tgt);
            step();
            check(tbl[i].name, outs(), tbl[i].exp);
        end

        // Disable with three ops queued: all three must issue in order, then nothing.
        drive(1, 0, 0, 1, 0, jalr(1, 5), 32'h1000, 32'h2000);
        step();
        drive(1, 0, 0, 1, 0, jalr(5, 1), 32'h1100, 32'h2100);
        step();
        check("drain_stall", 71'(stall_o), 71'd1);
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (push_o) seen.push_back({1'b0, push_addr_o});
            if (pop_o)  seen.push_back({1'b1, pop_addr_o});
            step();
        end
        exp_ops[0] = {1'b0, 32'h1004};
        exp_ops[1] = {1'b1, 32'h2100};
        exp_ops[2] = {1'b0, 32'h1104};
        check("drain_op_count", 71'(seen.size()), 71'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) check($sformatf("drain_op%0d", i), 71'(seen[i]), 71'(exp_ops[i]));
        end
        check("drain_done", outs(), zero);

        // Async reset in the middle of a drain clears every output without a clock edge.
        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        step();
        drive(1, 0, 0, 1, 0, jalr(1, 5), 32'h4000, 32'h5000);
        step();
        drive(1, 0, 0, 1, 0, jalr(5, 1), 32'h4100, 32'h5100);
        step();
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        step();
        check("drain_pending", outs(), po(32'h5100));
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset", outs(), zero);
        #2;
        rst_ni = 1'b1;
        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        check("after_reset_empty", outs(), zero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
